// File: rtl/decode_stage_if.sv
// Fetch-to-decode, writeback and decode/execute latch signals of the decode stage.
// The slave modport is the decode stage; the master modport is whoever drives it.
interface decode_stage_if;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic [31:0] pc_step_in;
    logic        jump_taken;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] pc_out;
    logic [31:0] pc_step_out;
    logic [31:0] instr_out;
    logic        en_uncond_jmp;
    logic        en_rel_reg_jmp;
    logic        en_branch;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        hazard_stall;

    modport master (
        output instr_in, pc_in, pc_step_in, jump_taken, stall, wb_en, wb_rd, wb_data,
        input  rs1_data, rs2_data, imm, rd, pc_out, pc_step_out, instr_out,
               en_uncond_jmp, en_rel_reg_jmp, en_branch, mem_rd, mem_wr, reg_wr,
               hazard_stall
    );

    modport slave (
        input  instr_in, pc_in, pc_step_in, jump_taken, stall, wb_en, wb_rd, wb_data,
        output rs1_data, rs2_data, imm, rd, pc_out, pc_step_out, instr_out,
               en_uncond_jmp, en_rel_reg_jmp, en_branch, mem_rd, mem_wr, reg_wr,
               hazard_stall
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: register file, immediate/control decode, decode/execute latch,
// load-use hazard detection. Define DECODE_WB_BYPASS_EN for same-cycle writeback bypass.
module decode_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          RF_DEPTH  = 32
) (
    input logic          clk,
    input logic          rst,
    decode_stage_if.slave bus
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_JALR   = 7'b1100111,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_REG    = 7'b0110011
    } opcode_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_step;
        logic [4:0]  rd;
        logic        en_uncond_jmp;
        logic        en_rel_reg_jmp;
        logic        en_branch;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } dx_t;

    localparam dx_t BUBBLE = '{instr: NOP_INSTR, default: '0};

    logic [31:0] rf [RF_DEPTH];
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic        byp1;
    logic        byp2;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    dx_t         dec;
    dx_t         q;

    assign instr   = bus.instr_in;
    assign opcode  = instr[6:0];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];

`ifdef DECODE_WB_BYPASS_EN
    assign byp1 = bus.wb_en && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs1_idx);
    assign byp2 = bus.wb_en && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs2_idx);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // Writeback ignores stall so a load returning under a cache stall is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the register file is architecturally cleared on reset, so it is a
            // flop array with a reset loop rather than an inferred RAM.
            for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
        end else if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
            rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        dec         = '0;
        dec.instr   = instr;
        dec.pc      = bus.pc_in;
        dec.pc_step = bus.pc_step_in;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        writes_rd   = 1'b0;
        dec.rs1_data = (rs1_idx == 5'd0) ? '0 : (byp1 ? bus.wb_data : rf[rs1_idx]);
        dec.rs2_data = (rs2_idx == 5'd0) ? '0 : (byp2 ? bus.wb_data : rf[rs2_idx]);
        case (opcode)
            OP_LOAD: begin
                dec.imm    = {{20{instr[31]}}, instr[31:20]};
                dec.mem_rd = 1'b1;
                uses_rs1   = 1'b1;
                writes_rd  = 1'b1;
            end
            OP_IMM: begin
                dec.imm   = {{20{instr[31]}}, instr[31:20]};
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_JALR: begin
                dec.imm            = {{20{instr[31]}}, instr[31:20]};
                dec.en_rel_reg_jmp = 1'b1;
                uses_rs1           = 1'b1;
                writes_rd          = 1'b1;
            end
            OP_STORE: begin
                dec.imm    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec.mem_wr = 1'b1;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_BRANCH: begin
                dec.imm       = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                dec.en_branch = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec.imm   = {instr[31:12], 12'b0};
                writes_rd = 1'b1;
            end
            OP_JAL: begin
                dec.imm           = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                dec.en_uncond_jmp = 1'b1;
                writes_rd         = 1'b1;
            end
            OP_REG: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
        dec.rd     = writes_rd ? instr[11:7] : 5'd0;
        dec.reg_wr = writes_rd && (instr[11:7] != 5'd0);
    end

    // A load now in the latch cannot deliver its data to the instruction behind it.
    assign bus.hazard_stall = q.mem_rd && (q.rd != 5'd0) &&
                              (((q.rd == rs1_idx) && uses_rs1) || ((q.rd == rs2_idx) && uses_rs2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= BUBBLE;
        end else if (!bus.stall) begin
            if (bus.jump_taken || bus.hazard_stall) q <= BUBBLE;
            else                                   q <= dec;
        end
    end

    assign bus.instr_out      = q.instr;
    assign bus.rs1_data       = q.rs1_data;
    assign bus.rs2_data       = q.rs2_data;
    assign bus.imm            = q.imm;
    assign bus.pc_out         = q.pc;
    assign bus.pc_step_out    = q.pc_step;
    assign bus.rd             = q.rd;
    assign bus.en_uncond_jmp  = q.en_uncond_jmp;
    assign bus.en_rel_reg_jmp = q.en_rel_reg_jmp;
    assign bus.en_branch      = q.en_branch;
    assign bus.mem_rd         = q.mem_rd;
    assign bus.mem_wr         = q.mem_wr;
    assign bus.reg_wr         = q.reg_wr;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage, directly downstream of the fetch stage.
- Consumes the fetched instruction and its PC values.
- Reads the 32x32 register file and generates the RV32I immediate and control flags.
- Registers all of this into the decode/execute pipeline latch.
- Detects load-use hazards and squashes wrong-path instructions after a taken jump.

Parameters:
- NOP_INSTR, 32'h00000013, encoding injected as a bubble (addi x0,x0,0).
- RF_DEPTH, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- instr_in  in  32  instruction from fetch latch
- pc_in  in  32  current address from fetch latch
- pc_step_in  in  32  current address + 4 from fetch latch
- jump_taken  in  1  fetch redirected this cycle; squash
- stall  in  1  data-cache stall; hold all state
- wb_en  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback value
- rs1_data  out  32  latched operand 1
- rs2_data  out  32  latched operand 2
- imm  out  32  latched sign-extended immediate
- rd  out  5  latched destination
- pc_out  out  32  latched PC (to fetch curr_addr_in)
- pc_step_out  out  32  latched PC + 4
- instr_out  out  32  latched instruction
- en_uncond_jmp  out  1  latched JAL
- en_rel_reg_jmp  out  1  latched JALR
- en_branch  out  1  latched B-type
- mem_rd  out  1  latched load
- mem_wr  out  1  latched store
- reg_wr  out  1  latched register write (0 when rd = 0)
- hazard_stall  out  1  combinational; fetch must hold PC and its latches

Behaviour:
Reset:
- While rst = 0, all latched outputs take their bubble values: instr_out = NOP_INSTR, all control flags 0, data/address outputs 0.
- All register-file entries clear to 0.

Latency:
- One cycle. Decode is combinational from the *_in ports, captured on the rising clk edge.

Register file:
- Two asynchronous read ports indexed by instr_in[19:15] and instr_in[24:20].
- One synchronous write port: on a clk edge with wb_en = 1 and wb_rd != 0, write wb_data.
- Writes to x0 are ignored; reads of x0 always return 0.
- Writeback is never blocked by stall.

Immediate, selected by opcode instr_in[6:0], always sign-extended from instr[31]:
- I-type (0000011, 0010011, 1100111): instr[31:20].
- S-type (0100011): {instr[31:25], instr[11:7]}.
- B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U-type (0110111, 0010111): {instr[31:12], 12'b0}.
- J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Unknown opcode: imm = 0, all flags 0 (treated as a bubble).

Latch update, by priority:
1. stall = 1: hold everything. hazard_stall is still computed but has no effect.
2. jump_taken = 1: load the bubble. This overrides hazard_stall.
3. hazard_stall = 1: load the bubble. The fetch latch holds, so the same instruction is re-presented next cycle.
4. Otherwise: load the decoded values.

Load-use hazard:
- hazard_stall = mem_rd & (rd != 0) & ((rd == rs1 idx & opcode uses rs1) | (rd == rs2 idx & opcode uses rs2)).
- U-type and J-type use neither source; I-type and loads use rs1 only.

Simultaneous write and read of the same register:
- The behaviour depends on WB_BYPASS_EN; see Optional Feature.

Optional Feature:
Macro: DECODE_WB_BYPASS_EN.
- Defined: a read port whose index equals wb_rd (nonzero) while wb_en = 1 returns wb_data in the same cycle, so the latched operand is the new value.
- Undefined: the read returns the pre-write register contents. Execute-stage forwarding must cover this case.

Test Plan:
- Reset and x0:
  - Stimulus: hold rst = 0 for 3 cycles, release, then issue a write of 0xDEADBEEF to x0.
  - Required: instr_out = 0x13, all flags 0, rs1_data = 0. Reading x0 afterwards returns 0.
- Immediates:
  - Stimulus: instr_in = 0xFFF00093 (addi x1,x0,-1).
  - Required: next cycle imm = 0xFFFFFFFF, rd = 1, reg_wr = 1.
  - Stimulus: instr_in = 0x008000EF (jal x1,8).
  - Required: imm = 8, en_uncond_jmp = 1.
- Load-use:
  - Stimulus: lw x5,0(x2) followed by add x6,x5,x7.
  - Required: hazard_stall = 1 for exactly 1 cycle, one bubble reaches the latch, then the add is latched.
- Flush and priority:
  - Stimulus: jump_taken = 1 while instr_in = beq encoding 0x00208463.
  - Required: latch holds the bubble, en_branch = 0.
  - Stimulus: jump_taken and stall both 1.
  - Required: latch holds its previous value.
- Bypass:
  - Stimulus: wb_en = 1, wb_rd = 3, wb_data = 0x1234 in the same cycle as add x4,x3,x0 is decoded.
  - Required: rs1_data = 0x1234 with DECODE_WB_BYPASS_EN defined; the old x3 value without it.
- Async reset mid-run:
  - Stimulus: drop rst between clock edges while reg_wr = 1.
  - Required: outputs clear immediately, without waiting for a clock edge.
